// File: rtl/freq_div_monitor_if.sv
// Signal bundle between the divided clock under test, the period monitor and its status consumer.
interface freq_div_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic             div_clk_in;
  logic             enable;
  logic             clear_err;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             lock;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output div_clk_in, enable, clear_err,
    input  period_out, period_valid, lock, err_pulse, err_count, state
  );

  modport slave (
    input  div_clk_in, enable, clear_err,
    output period_out, period_valid, lock, err_pulse, err_count, state
  );
endinterface

// File: rtl/freq_div_monitor.sv
// Measures the period of a divided clock in fast-clock cycles, locks on the expected ratio
// and flags/counts later period errors or stalls.
module freq_div_monitor #(
  parameter int EXP_PERIOD = 3,
  parameter int CNT_W      = 8,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 8,
  parameter int ERR_W      = 8
) (
  input logic               clk,
  input logic               rst,
  freq_div_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  EXP_CNT     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ZERO    = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [GOOD_W-1:0] GOOD_ZERO   = {GOOD_W{1'b0}};
  localparam logic [GOOD_W-1:0] GOOD_ONE    = {{(GOOD_W-1){1'b0}}, 1'b1};
  localparam logic [GOOD_W-1:0] LOCK_CNT    = GOOD_W'(LOCK_N);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    if (v == ERR_MAX) begin
      return v;
    end else begin
      return v + ERR_ONE;
    end
  endfunction

  state_t            state_r;
  logic              s1_r, s2_r, s3_r, rise_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              seen_r;
  logic              stalled_r;
  logic [GOOD_W-1:0] good_cnt_r;
  logic [CNT_W-1:0]  period_out_r;
  logic              period_valid_r;
  logic              lock_r;
  logic              err_pulse_r;
  logic [ERR_W-1:0]  err_count_r;

  logic meas_s, good_s, fault_s, stall_s, lock_err_s;

  // Events seen by the FSM this cycle; all derived from registered state only.
  assign meas_s     = rise_r & seen_r;
  assign good_s     = meas_s & (cnt_r == EXP_CNT);
  assign stall_s    = seen_r & ~rise_r & ~stalled_r & (cnt_r == TIMEOUT_CNT);
  assign fault_s    = (meas_s & (cnt_r != EXP_CNT)) | stall_s;
  assign lock_err_s = mon.enable & (state_r == LOCKED) & fault_s;

  // Edge synchroniser, period counter, lock FSM and error accounting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      s1_r           <= 1'b0;
      s2_r           <= 1'b0;
      s3_r           <= 1'b0;
      rise_r         <= 1'b0;
      cnt_r          <= CNT_ZERO;
      seen_r         <= 1'b0;
      stalled_r      <= 1'b0;
      good_cnt_r     <= GOOD_ZERO;
      period_out_r   <= CNT_ZERO;
      period_valid_r <= 1'b0;
      lock_r         <= 1'b0;
      err_pulse_r    <= 1'b0;
      err_count_r    <= ERR_ZERO;
    end else begin
      s1_r           <= mon.div_clk_in;
      s2_r           <= s1_r;
      s3_r           <= s2_r;
      rise_r         <= s2_r & ~s3_r;
      period_valid_r <= 1'b0;
      err_pulse_r    <= lock_err_s;

      // A clear that coincides with an error still leaves the count at zero.
      if (mon.clear_err) begin
        err_count_r <= ERR_ZERO;
      end else if (lock_err_s) begin
        err_count_r <= err_sat_inc(err_count_r);
      end else begin
        err_count_r <= err_count_r;
      end

      if (!mon.enable) begin
        state_r    <= IDLE;
        lock_r     <= 1'b0;
        cnt_r      <= CNT_ZERO;
        seen_r     <= 1'b0;
        stalled_r  <= 1'b0;
        good_cnt_r <= GOOD_ZERO;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= ACQUIRE;
            lock_r  <= 1'b0;
          end
          ACQUIRE: begin
            if (good_cnt_r == LOCK_CNT) begin
              state_r    <= LOCKED;
              lock_r     <= 1'b1;
              good_cnt_r <= GOOD_ZERO;
            end else if (good_s) begin
              good_cnt_r <= good_cnt_r + GOOD_ONE;
            end else if (fault_s) begin
              good_cnt_r <= GOOD_ZERO;
            end else begin
              good_cnt_r <= good_cnt_r;
            end
          end
          LOCKED: begin
            if (fault_s) begin
              state_r <= ERROR;
              lock_r  <= 1'b0;
            end else begin
              state_r <= LOCKED;
              lock_r  <= 1'b1;
            end
          end
          ERROR: begin
            state_r    <= ACQUIRE;
            lock_r     <= 1'b0;
            good_cnt_r <= GOOD_ZERO;
          end
          default: begin
            state_r <= IDLE;
            lock_r  <= 1'b0;
          end
        endcase

        // The first rise after IDLE only arms the measurement; seen survives ERROR.
        if (state_r == IDLE) begin
          cnt_r      <= CNT_ZERO;
          seen_r     <= 1'b0;
          stalled_r  <= 1'b0;
          good_cnt_r <= GOOD_ZERO;
        end else if (rise_r) begin
          cnt_r     <= CNT_ONE;
          seen_r    <= 1'b1;
          stalled_r <= 1'b0;
          if (seen_r) begin
            period_out_r   <= cnt_r;
            period_valid_r <= 1'b1;
          end else begin
            period_out_r <= period_out_r;
          end
        end else begin
          cnt_r <= cnt_sat_inc(cnt_r);
          if (stall_s) begin
            stalled_r <= 1'b1;
          end else begin
            stalled_r <= stalled_r;
          end
        end
      end
    end
  end

  assign mon.period_out   = period_out_r;
  assign mon.period_valid = period_valid_r;
  assign mon.lock         = lock_r;
  assign mon.err_pulse    = err_pulse_r;
  assign mon.err_count    = err_count_r;
  assign mon.state        = state_r;

endmodule

// File: tb/tb_freq_div_monitor.sv
// Directed bench for freq_div_monitor: stimulus pushes expected periods/error counts into
// queues, a negedge monitor pops and compares them whenever the DUT pulses an output.
`timescale 1ns/1ps
module tb_freq_div_monitor;

  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;

  freq_div_monitor_if #(.CNT_W(8), .ERR_W(8)) dut_if ();

  freq_div_monitor #(
    .EXP_PERIOD(3), .CNT_W(8), .LOCK_N(4), .TIMEOUT(TIMEOUT), .ERR_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (dut_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int exp_per_q[$];
  int exp_err_q[$];

  // reference model of the lock/error behaviour at period granularity
  bit m_locked   = 1'b0;
  int m_good     = 0;
  int m_err      = 0;
  bit m_clear    = 1'b0;
  int m_last_per = 0;
  bit have_rise  = 1'b0;
  int prev_len   = 0;

  int first_valid_cyc = -1;
  int last_err_cyc    = -1;
  int last_rise_cyc   = 0;
  int r1_cyc          = 0;
  int stall_rise_cyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (dut_if.period_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_per_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL period_unexpected: got period %0d with nothing expected (cycle %0d)",
                 dut_if.period_out, cyc);
      end else begin
        chk("period_out", int'(dut_if.period_out), exp_per_q.pop_front());
      end
    end
    if (dut_if.err_pulse) begin
      last_err_cyc = cyc;
      if (exp_err_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL err_unexpected: got err_pulse, err_count %0d, none expected (cycle %0d)",
                 dut_if.err_count, cyc);
      end else begin
        chk("err_count", int'(dut_if.err_count), exp_err_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_err();
    m_locked = 1'b0;
    m_good   = 0;
    if (m_clear) m_err = 0;
    else if (m_err < 255) m_err++;
    exp_err_q.push_back(m_err);
  endtask

  task automatic model_meas(input int len);
    exp_per_q.push_back(len);
    m_last_per = len;
    if (len == 3) begin
      if (!m_locked) begin
        m_good++;
        if (m_good == 4) begin
          m_locked = 1'b1;
          m_good   = 0;
        end
      end
    end else if (m_locked) begin
      model_err();
    end else begin
      m_good = 0;
    end
  endtask

  task automatic model_stall();
    if (m_locked) model_err();
    else m_good = 0;
  endtask

  // One divided-clock period starting with a rise; its rise closes the previous period.
  task automatic send_period(input int len, input int hi);
    bit do_chk;
    bit exp_lk;
    do_chk = have_rise && (prev_len >= 3);
    exp_lk = m_locked;
    if (have_rise) model_meas(prev_len);
    if (len > TIMEOUT) model_stall();
    for (int i = 0; i < len; i++) begin
      dut_if.div_clk_in = (i < hi);
      tick();
      if (i == 0) last_rise_cyc = cyc;
      if (i == 2 && do_chk) begin
        chk("lock", int'(dut_if.lock), int'(exp_lk));
        chk("state", int'(dut_if.state), exp_lk ? 2 : 1);
      end
    end
    have_rise = 1'b1;
    prev_len  = len;
  endtask

  task automatic send(input int len);
    send_period(len, (len >= 4) ? 2 : 1);
  endtask

  task automatic start_phase();
    dut_if.enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_phase(input bit use_rst);
    repeat (3) tick();
    chk("end_lock", int'(dut_if.lock), int'(m_locked));
    chk("end_state", int'(dut_if.state), m_locked ? 2 : 1);
    chk("end_err_count", int'(dut_if.err_count), m_err);
    dut_if.enable = 1'b0;
    if (use_rst) begin
      rst = 1'b0;
      tick();
      chk("rst_state", int'(dut_if.state), 0);
      chk("rst_lock", int'(dut_if.lock), 0);
      chk("rst_period_out", int'(dut_if.period_out), 0);
      chk("rst_period_valid", int'(dut_if.period_valid), 0);
      chk("rst_err_pulse", int'(dut_if.err_pulse), 0);
      chk("rst_err_count", int'(dut_if.err_count), 0);
      rst        = 1'b1;
      m_err      = 0;
      m_last_per = 0;
    end else begin
      tick();
      chk("idle_state", int'(dut_if.state), 0);
      chk("idle_lock", int'(dut_if.lock), 0);
      chk("idle_period_out", int'(dut_if.period_out), m_last_per);
    end
    m_locked  = 1'b0;
    m_good    = 0;
    have_rise = 1'b0;
    prev_len  = 0;
    repeat (2) tick();
  endtask

  initial begin
    rst                = 1'b0;
    dut_if.div_clk_in  = 1'b0;
    dut_if.enable      = 1'b0;
    dut_if.clear_err   = 1'b0;
    repeat (2) tick();
    chk("reset_state", int'(dut_if.state), 0);
    chk("reset_lock", int'(dut_if.lock), 0);
    chk("reset_period_out", int'(dut_if.period_out), 0);
    chk("reset_period_valid", int'(dut_if.period_valid), 0);
    chk("reset_err_pulse", int'(dut_if.err_pulse), 0);
    chk("reset_err_count", int'(dut_if.err_count), 0);
    rst = 1'b1;
    repeat (2) tick();

    // clean divide-by-3 input
    start_phase();
    send(3);
    send(3);
    r1_cyc = last_rise_cyc;
    repeat (10) send(3);
    end_phase(1'b0);
    chk("valid_latency", first_valid_cyc - r1_cyc, 3);

    // one long period, then a period of exactly TIMEOUT cycles (bad, but no stall)
    start_phase();
    repeat (6) send(3);
    send(4);
    repeat (6) send(3);
    send(8);
    repeat (6) send(3);
    end_phase(1'b0);

    // stall while locked: a single error when the counter reaches TIMEOUT
    start_phase();
    repeat (6) send(3);
    send_period(20, 1);
    stall_rise_cyc = last_rise_cyc;
    chk("stall_latency", last_err_cyc - stall_rise_cyc, 11);
    repeat (6) send(3);
    end_phase(1'b0);

    // acquisition sequence 3,3,2,3,3,3,3 then closing rise
    start_phase();
    send(3); send(3); send(2);
    repeat (5) send(3);
    end_phase(1'b0);

    // enable dropped during ACQUIRE
    start_phase();
    repeat (3) send(3);
    end_phase(1'b0);

    // error-count saturation, clear coinciding with an error, then reset while locked
    start_phase();
    repeat (5) send(3);
    for (int k = 0; k < 300; k++) begin
      send(4);
      repeat (4) send(3);
    end
    dut_if.clear_err = 1'b1;
    m_clear          = 1'b1;
    m_err            = 0;
    send(4);
    repeat (3) send(3);
    dut_if.clear_err = 1'b0;
    m_clear          = 1'b0;
    repeat (4) send(3);
    end_phase(1'b1);

    chk("period_queue_drained", exp_per_q.size(), 0);
    chk("err_queue_drained", exp_err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/freq_div_monitor.md
# freq_div_monitor

Checker stage sitting directly downstream of the divide-by-3 clock divider. It samples the divided clock on the same fast `clk` and measures its period in `clk` cycles. It locks once the measured period matches the expected ratio for several consecutive periods, then flags and counts any later period error or stall. Its outputs feed the phase-4 status/debug registers and the synthesis-netlist SDF bench.

## Interface
- `EXP_PERIOD`, 3: expected divided-clock period in `clk` cycles
- `CNT_W`, 8: width of period counter and `period_out`
- `LOCK_N`, 4: consecutive correct periods required to lock
- `TIMEOUT`, 8: cycles with no rising edge before a stall error is declared; must be less than 2^CNT_W - 1
- `ERR_W`, 8: width of `err_count`
- `clk`  in  1  fast reference clock, the same clock that drives the divider
- `rst`  in  1  synchronous, active-low reset, sampled on `clk` rising edge
- `div_clk_in`  in  1  divided clock under test (the divider's `out_clk`)
- `enable`  in  1  monitor enable; 0 forces IDLE
- `clear_err`  in  1  synchronous clear of `err_count`
- `period_out`  out  CNT_W  last measured period
- `period_valid`  out  1  one-cycle pulse when `period_out` updates
- `lock`  out  1  high while in LOCKED
- `err_pulse`  out  1  one-cycle pulse per detected error (LOCKED only)
- `err_count`  out  ERR_W  saturating error count
- `state`  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, ERROR=3

## Operation
- Input path: `div_clk_in` passes through 2 sync flops (s1, s2) and a history flop s3.
  - A rise is detected when s2=1 and s3=0.
  - No combinational path exists from `div_clk_in` to any output.
- Period counter `cnt` (CNT_W bits):
  - Increments every cycle while not IDLE; saturates at all-ones.
  - On a rise, `cnt` loads 1.
- First-edge handling:
  - The first rise after entering ACQUIRE from IDLE only sets the internal `seen` flag and loads `cnt`=1.
  - It does not produce a measurement.
- Measurement: on each later rise, `period_out` <= `cnt` and `period_valid` pulses. A period is "good" when it equals EXP_PERIOD.
- Stall detection:
  - When `seen`=1 and `cnt` reaches TIMEOUT with no rise, a stall event fires once.
  - The internal `stalled` flag suppresses repeats until the next rise.
  - A stall does not update `period_out`.
- FSM, all transitions registered:
  - IDLE: `cnt`, `seen`, `stalled` and the good counter are held at 0. `enable`=1 moves to ACQUIRE.
  - ACQUIRE:
    - A good period increments the good counter.
    - A bad period or a stall resets the good counter to 0, with no `err_pulse`.
    - When the good counter reaches LOCK_N, the FSM moves to LOCKED.
  - LOCKED: a bad period or a stall asserts `err_pulse` for one cycle, increments `err_count` (saturating at all-ones), and moves to ERROR.
  - ERROR: lasts exactly one cycle, then moves to ACQUIRE with the good counter at 0. `seen` stays set, so measurement continues uninterrupted.
  - `enable`=0 in any state moves to IDLE on the next edge. This takes priority over all other transitions. `period_out` holds its value.
- `clear_err`: `err_count` <= 0. If it coincides with an error, clear wins and the count is 0; `err_pulse` still fires.
- `lock` = (`state` == LOCKED), registered.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - All outputs and internal state go to 0; `state`=IDLE.
  - Reset mid-operation aborts immediately, including in LOCKED and ERROR.
- Detection latency: a `div_clk_in` rise sampled at edge N produces the rise condition at edge N+2. The resulting `period_valid`, `period_out` and `err_pulse` are registered at edge N+3.
- Lock latency after enable: first rise, then LOCK_N good periods. `lock` rises on the cycle after the LOCK_N-th `period_valid`.
- For a clean divide-by-3 input: `period_valid` pulses every 3 cycles and `period_out`=3 constantly.
- Duty cycle is not checked. A 1.5-cycle high time may sample as a 1- or 2-cycle high; this is legal.

## Test plan
- Connect the `frequency_divider_by3` netlist with a 5 ns `clk`, `rst` low for 2 cycles, then `enable`=1 → `period_out`=3 on every `period_valid`; `lock`=1 after the first rise plus 4 good periods; `err_count`=0.
- Once locked, insert one period of 4 cycles on `div_clk_in` → one `err_pulse`; `err_count`=1; `state` goes LOCKED→ERROR→ACQUIRE; relock after 4 more good periods.
- Once locked, hold `div_clk_in` low → `err_pulse` exactly once, at `cnt`=8; `err_count`=1; no further errors while stalled. Resuming edges → relock.
- Force 300 errors, alternating 4-cycle periods with relocks → `err_count` saturates at 255. `clear_err` coinciding with an error → `err_count`=0.
- In ACQUIRE, send the sequence 3,3,2,3,3,3,3 → no `err_pulse`; the good counter resets at 2; `lock` asserts only after the final four 3s.
- Assert `rst`=0 while LOCKED → next edge: all outputs 0, `state`=IDLE. Drop `enable` in ACQUIRE → IDLE next edge; `period_out` retained.
